// File: rtl/xif_mem_sequencer.sv
// XIF memory sequencer: splits one FLEN-wide FP load/store into aligned beats, reassembles results, one done pulse.
// Latency BEATS+2 cycles best case (misaligned: 1); beats hold stable while mem_ready is low, op_ready low while busy.
module xif_mem_sequencer #(
   parameter int FLEN        = 32,
   parameter int X_MEM_WIDTH = 32,
   parameter int X_ID_WIDTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     op_valid,
   output logic                     op_ready,
   input  logic                     op_we,
   input  logic [X_ID_WIDTH-1:0]    op_id,
   input  logic [31:0]              op_addr,
   input  logic [1:0]               op_mode,
   input  logic                     op_spec,
   input  logic [FLEN-1:0]          op_wdata,
   output logic                     mem_valid,
   input  logic                     mem_ready,
   output logic [X_ID_WIDTH-1:0]    mem_id,
   output logic [31:0]              mem_addr,
   output logic [1:0]               mem_mode,
   output logic                     mem_we,
   output logic [2:0]               mem_size,
   output logic [X_MEM_WIDTH/8-1:0] mem_be,
   output logic [1:0]               mem_attr,
   output logic [X_MEM_WIDTH-1:0]   mem_wdata,
   output logic                     mem_last,
   output logic                     mem_spec,
   input  logic                     mem_result_valid,
   input  logic [X_ID_WIDTH-1:0]    mem_result_id,
   input  logic [X_MEM_WIDTH-1:0]   mem_result_rdata,
   input  logic                     mem_result_err,
   output logic                     done_valid,
   output logic [X_ID_WIDTH-1:0]    done_id,
   output logic                     done_we,
   output logic [FLEN-1:0]          done_rdata,
   output logic                     done_err,
   output logic                     done_misaligned
);
   localparam int BEATS = FLEN / X_MEM_WIDTH;
   localparam int BB    = X_MEM_WIDTH / 8;
   localparam int OFFW  = $clog2(BB);
   localparam int CW    = $clog2(BEATS + 1);
   localparam logic [2:0] SIZE = 3'(OFFW);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                r_state;
   logic [CW-1:0]         r_req_cnt;
   logic [CW-1:0]         r_rsp_cnt;
   logic [FLEN-1:0]       r_wsh;
   logic [FLEN-1:0]       r_rdata;
   logic [31:0]           r_addr;
   logic [X_ID_WIDTH-1:0] r_id;
   logic [1:0]            r_mode;
   logic                  r_we;
   logic                  r_spec;
   logic                  r_err;
   logic                  r_mis;
   logic                  r_op_rdy;
   logic                  r_mem_vld;
   logic                  r_mem_last;
   logic                  r_done_vld;

   logic                  w_res_acc;
   logic [CW-1:0]         w_rsp_nxt;
   logic                  w_req_last;

   // A result only counts against a beat that has already handshaken, so stale or foreign ids fall through.
   assign w_res_acc  = mem_result_valid && (mem_result_id == r_id) && (r_rsp_cnt < r_req_cnt) &&
                       ((r_state == ISSUE) || (r_state == DRAIN));
   assign w_rsp_nxt  = r_rsp_cnt + CW'(w_res_acc);
   assign w_req_last = (r_req_cnt == CW'(BEATS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_req_cnt  <= '0;
         r_rsp_cnt  <= '0;
         r_wsh      <= '0;
         r_rdata    <= '0;
         r_addr     <= '0;
         r_id       <= '0;
         r_mode     <= '0;
         r_we       <= 1'b0;
         r_spec     <= 1'b0;
         r_err      <= 1'b0;
         r_mis      <= 1'b0;
         r_op_rdy   <= 1'b1;
         r_mem_vld  <= 1'b0;
         r_mem_last <= 1'b0;
         r_done_vld <= 1'b0;
      end else begin
         r_done_vld <= 1'b0;
         if (w_res_acc) begin
            if (!r_we)
               r_rdata[r_rsp_cnt*X_MEM_WIDTH +: X_MEM_WIDTH] <= mem_result_rdata;
            r_err     <= r_err | mem_result_err;
            r_rsp_cnt <= w_rsp_nxt;
         end
         case (r_state)
            IDLE: begin
               if (op_valid) begin
                  r_id       <= op_id;
                  r_we       <= op_we;
                  r_mode     <= op_mode;
                  r_spec     <= op_spec;
                  r_addr     <= op_addr;
                  r_wsh      <= op_wdata;
                  r_err      <= 1'b0;
                  r_req_cnt  <= '0;
                  r_rsp_cnt  <= '0;
                  r_op_rdy   <= 1'b0;
                  r_mem_last <= (BEATS == 1);
                  if (op_addr[OFFW-1:0] != '0) begin
                     r_mis      <= 1'b1;
                     r_done_vld <= 1'b1;
                     r_state    <= DONE;
                  end else begin
                     r_mis     <= 1'b0;
                     r_mem_vld <= 1'b1;
                     r_state   <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (mem_ready) begin
                  r_req_cnt  <= r_req_cnt + CW'(1);
                  r_addr     <= r_addr + 32'(BB);
                  r_wsh      <= r_wsh >> X_MEM_WIDTH;
                  r_mem_last <= (r_req_cnt == CW'(BEATS - 2));
                  // An error already seen stops further beats; the one just accepted still counts.
                  if (w_req_last || r_err) begin
                     r_mem_vld <= 1'b0;
                     r_state   <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (w_rsp_nxt == r_req_cnt) begin
                  r_done_vld <= 1'b1;
                  r_state    <= DONE;
               end
            end
            DONE: begin
               r_op_rdy <= 1'b1;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign op_ready        = r_op_rdy;
   assign mem_valid       = r_mem_vld;
   assign mem_id          = r_id;
   assign mem_addr        = r_addr;
   assign mem_mode        = r_mode;
   assign mem_we          = r_we;
   assign mem_size        = r_mem_vld ? SIZE : 3'b000;
   assign mem_be          = r_mem_vld ? '1 : '0;
   assign mem_attr        = 2'b00;
   assign mem_wdata       = r_wsh[X_MEM_WIDTH-1:0];
   assign mem_last        = r_mem_last;
   assign mem_spec        = r_spec;
   assign done_valid      = r_done_vld;
   assign done_id         = r_id;
   assign done_we         = r_we;
   assign done_rdata      = r_rdata;
   assign done_err        = r_err;
   assign done_misaligned = r_mis;
endmodule

// File: tb/tb_xif_mem_sequencer.sv
// Bench for xif_mem_sequencer (FLEN=64, X_MEM_WIDTH=32): directed table, reset corner cases, randomized ops vs a timing/data model.
module tb_xif_mem_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid, op_ready, op_we, op_spec;
   logic [3:0]  op_id;
   logic [31:0] op_addr;
   logic [1:0]  op_mode;
   logic [63:0] op_wdata;
   logic        mem_valid, mem_ready, mem_we, mem_last, mem_spec;
   logic [3:0]  mem_id, mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic [1:0]  mem_mode, mem_attr;
   logic [2:0]  mem_size;
   logic        mem_result_valid, mem_result_err;
   logic [3:0]  mem_result_id;
   logic [31:0] mem_result_rdata;
   logic        done_valid, done_we, done_err, done_misaligned;
   logic [3:0]  done_id;
   logic [63:0] done_rdata;

   int n_chk = 0;
   int n_err = 0;

   xif_mem_sequencer #(.FLEN(64), .X_MEM_WIDTH(32), .X_ID_WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .op_valid(op_valid), .op_ready(op_ready), .op_we(op_we), .op_id(op_id), .op_addr(op_addr),
      .op_mode(op_mode), .op_spec(op_spec), .op_wdata(op_wdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_id(mem_id), .mem_addr(mem_addr),
      .mem_mode(mem_mode), .mem_we(mem_we), .mem_size(mem_size), .mem_be(mem_be), .mem_attr(mem_attr),
      .mem_wdata(mem_wdata), .mem_last(mem_last), .mem_spec(mem_spec),
      .mem_result_valid(mem_result_valid), .mem_result_id(mem_result_id),
      .mem_result_rdata(mem_result_rdata), .mem_result_err(mem_result_err),
      .done_valid(done_valid), .done_id(done_id), .done_we(done_we), .done_rdata(done_rdata),
      .done_err(done_err), .done_misaligned(done_misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [3:0]  id;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic [1:0]  err;
      int          st0, st1, lat0, lat1;
      logic [63:0] x_rdata;
      logic        x_err;
      logic        x_mis;
      int          x_done;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [3:0] id, input logic [31:0] addr,
                               input logic [63:0] wdata, input logic [63:0] rdata, input logic [1:0] err,
                               input int st0, input int st1, input int lat0, input int lat1,
                               input logic [63:0] x_rdata, input logic x_err, input logic x_mis, input int x_done);
      vec_t v;
      v.we = we; v.id = id; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
      v.st0 = st0; v.st1 = st1; v.lat0 = lat0; v.lat1 = lat1;
      v.x_rdata = x_rdata; v.x_err = x_err; v.x_mis = x_mis; v.x_done = x_done;
      return v;
   endfunction

   // Reference: two 32-bit beats, one result per cycle in order, done the cycle after the last result.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      int hs0, hs1, r0, r1;
      if (v.addr[1:0] != 2'b00) begin
         r.x_mis = 1'b1; r.x_err = 1'b0; r.x_done = 1; r.x_rdata = '0;
      end else begin
         hs0 = 1 + v.st0;
         hs1 = hs0 + 1 + v.st1;
         r0  = hs0 + v.lat0;
         r1  = hs1 + v.lat1;
         if (r1 <= r0) r1 = r0 + 1;
         r.x_mis = 1'b0; r.x_err = |v.err; r.x_done = r1 + 1; r.x_rdata = v.rdata;
      end
      return r;
   endfunction

   task automatic run_op(input vec_t v, input bit spur);
      int  due[$];
      int  nb = 0, nr = 0, wait_cnt = 0, exp_beats;
      bit  finished = 0, real_r;
      exp_beats = v.x_mis ? 0 : 2;
      op_valid = 1'b1; op_we = v.we; op_id = v.id; op_addr = v.addr;
      op_mode = 2'($urandom_range(0, 3)); op_spec = 1'($urandom_range(0, 1)); op_wdata = v.wdata;
      mem_ready = 1'b0; mem_result_valid = 1'b0;
      chk("op_ready_idle", {63'd0, op_ready}, 64'd1);
      tick();
      op_valid = 1'b0;
      for (int now = 1; now < 80 && !finished; now++) begin
         mem_ready = (nb == 0) ? (wait_cnt >= v.st0) : (nb == 1) ? (wait_cnt >= v.st1) : 1'b1;
         real_r = (due.size() > 0) && (due[0] <= now);
         if (real_r) begin
            mem_result_valid = 1'b1; mem_result_id = v.id;
            mem_result_rdata = v.rdata[nr*32 +: 32]; mem_result_err = v.err[nr];
         end else if (spur && $urandom_range(0, 2) == 0) begin
            mem_result_valid = 1'b1; mem_result_id = v.id ^ 4'($urandom_range(1, 15));
            mem_result_rdata = $urandom; mem_result_err = 1'b1;
         end else begin
            mem_result_valid = 1'b0;
         end
         chk("op_ready_busy", {63'd0, op_ready}, 64'd0);
         if (mem_valid) begin
            chk("beat_allowed", {63'd0, nb < exp_beats}, 64'd1);
            chk("mem_addr", {32'd0, mem_addr}, {32'd0, v.addr + 32'(4 * nb)});
            chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, v.wdata[(nb % 2)*32 +: 32]});
            chk("mem_last", {63'd0, mem_last}, {63'd0, nb == 1});
            chk("mem_id_we", {59'd0, mem_id, mem_we}, {59'd0, v.id, v.we});
            chk("mem_size_be_attr", {55'd0, mem_size, mem_be, mem_attr}, {55'd0, 3'd2, 4'hF, 2'd0});
            chk("mem_mode_spec", {61'd0, mem_mode, mem_spec}, {61'd0, op_mode, op_spec});
         end
         if (done_valid) begin
            finished = 1;
            chk("done_cycle", 64'(now), 64'(v.x_done));
            chk("done_id_we", {59'd0, done_id, done_we}, {59'd0, v.id, v.we});
            chk("done_err", {63'd0, done_err}, {63'd0, v.x_err});
            chk("done_misaligned", {63'd0, done_misaligned}, {63'd0, v.x_mis});
            if (!v.we && !v.x_mis) chk("done_rdata", done_rdata, v.x_rdata);
         end
         if (mem_valid && mem_ready) begin
            due.push_back(now + ((nb == 0) ? v.lat0 : v.lat1));
            nb++; wait_cnt = 0;
         end else if (mem_valid) begin
            wait_cnt++;
         end
         if (real_r) begin
            void'(due.pop_front());
            nr++;
         end
         tick();
      end
      mem_result_valid = 1'b0;
      if (!finished) chk("done_timeout", 64'd0, 64'd1);
      chk("op_ready_after_done", {63'd0, op_ready}, 64'd1);
      chk("done_one_cycle", {63'd0, done_valid}, 64'd0);
      chk("beats_issued", 64'(nb), 64'(exp_beats));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[6];
      vec_t v;
      tbl[0] = mk(0, 4'd3, 32'h0000_1000, 64'h0, 64'h5555FFFF_AAAA0000, 2'b00, 0, 0, 1, 1,
                  64'h5555FFFF_AAAA0000, 0, 0, 4);
      tbl[1] = mk(1, 4'd5, 32'h0000_2000, 64'h11223344_55667788, 64'h0, 2'b00, 2, 0, 1, 1,
                  64'h0, 0, 0, 6);
      tbl[2] = mk(0, 4'd9, 32'h0000_4000, 64'h0, 64'hDEADBEEF_01234567, 2'b01, 0, 2, 1, 1,
                  64'hDEADBEEF_01234567, 1, 0, 6);
      tbl[3] = mk(0, 4'd2, 32'h0000_1002, 64'h0, 64'h0, 2'b00, 0, 0, 1, 1, 64'h0, 0, 1, 1);
      tbl[4] = mk(1, 4'd12, 32'h0000_8000, 64'hA5A5A5A5_5A5A5A5A, 64'h0, 2'b10, 0, 0, 3, 1,
                  64'h0, 1, 0, 6);
      tbl[5] = mk(0, 4'd15, 32'h0000_0100, 64'h0, 64'h01234567_89ABCDEF, 2'b00, 1, 1, 2, 1,
                  64'h01234567_89ABCDEF, 0, 0, 6);

      rst = 1'b1; op_valid = 1'b0; op_we = 1'b0; op_id = '0; op_addr = '0; op_mode = '0;
      op_spec = 1'b0; op_wdata = '0; mem_ready = 1'b0; mem_result_valid = 1'b0;
      mem_result_id = '0; mem_result_rdata = '0; mem_result_err = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_op_ready", {63'd0, op_ready}, 64'd1);
      chk("rst_mem", {27'd0, mem_valid, mem_addr, mem_size, mem_be}, 64'd0);
      chk("rst_done", {59'd0, done_valid, done_err, done_misaligned, done_we, done_id == 4'd0}, 64'd1);
      chk("rst_rdata", done_rdata, 64'd0);

      // Results while idle must be ignored.
      for (int i = 0; i < 3; i++) begin
         mem_result_valid = 1'b1; mem_result_id = 4'd3; mem_result_rdata = 32'hFFFF_FFFF; mem_result_err = 1'b1;
         tick();
         chk("idle_result_ignored", {62'd0, done_valid, op_ready}, 64'd1);
      end
      mem_result_valid = 1'b0;

      for (int i = 0; i < 6; i++) run_op(tbl[i], 1'b0);

      // Reset in the middle of ISSUE, then a late result for the killed op.
      op_valid = 1'b1; op_we = 1'b0; op_id = 4'd7; op_addr = 32'h0000_3000; mem_ready = 1'b0;
      tick();
      op_valid = 1'b0;
      chk("pre_rst_issue", {63'd0, mem_valid}, 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_mem", {30'd0, mem_valid, mem_last, mem_addr}, 64'd0);
      chk("midrst_ready_done", {62'd0, op_ready, done_valid}, 64'd2);
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mem_result_valid = 1'b1; mem_result_id = 4'd7; mem_result_rdata = 32'h1234_5678; mem_result_err = 1'b1;
         tick();
         chk("late_result_ignored", {62'd0, done_valid, op_ready}, 64'd1);
      end
      mem_result_valid = 1'b0;
      run_op(mk(0, 4'd6, 32'hFFFF_FFFC, 64'h0, 64'hCAFEF00D_12345678, 2'b00, 0, 0, 1, 1,
                64'hCAFEF00D_12345678, 0, 0, 4), 1'b0);

      for (int i = 0; i < 40; i++) begin
         v.we    = 1'($urandom_range(0, 1));
         v.id    = 4'($urandom_range(0, 15));
         v.addr  = ($urandom_range(0, 7) == 0) ? {$urandom} | 32'd1 : {$urandom} & 32'hFFFF_FFFC;
         v.wdata = {$urandom, $urandom};
         v.rdata = {$urandom, $urandom};
         v.err   = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
         v.st0   = $urandom_range(0, 3);
         v.st1   = $urandom_range(0, 3);
         v.lat0  = $urandom_range(1, 4);
         v.lat1  = $urandom_range(1, 4);
         run_op(model(v), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
